fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one 8-deep synchronous FIFO (WIDTH-bit data, full/empty flags, write request strobe) among NREQ producers. Each producer offers data on a valid/ready handshake; the arbiter grants one producer at a time, holds the grant for a bounded burst, and forwards accepted beats to the FIFO write port only when the FIFO is not full. It sits between the producer agents and the FIFO, and is the only block that drives the FIFO's write request.

## Interface

Parameters:
- WIDTH, 8, data width; matches FIFO Data_in.
- NREQ, 4, number of producers (power of two, 2..8).
- IDW, 2, grant id width = log2(NREQ).
- MAX_BURST, 4, max beats per grant (1..7).
- BCW, 3, burst counter width; holds 0..MAX_BURST.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-producer data valid.
- req_data  in  NREQ*WIDTH  producer i data is bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  per-producer accept; at most one bit is high.
- fifo_full  in  1  FIFO full flag.
- fifo_wreq  out  1  FIFO write request; one beat per high cycle.
- fifo_wdata  out  WIDTH  FIFO write data.
- grant_active  out  1  a producer currently owns the port.
- grant_id  out  IDW  index of the owner; valid while grant_active=1.
- beat_total  out  16  count of accepted beats; wraps at 2^16.

## Operation

- States: IDLE (no owner) and OWN (owner = grant_id). Registers: state, grant_id, rr_ptr (IDW), burst_cnt (BCW), beat_total.
- IDLE: if any req_valid bit is set, select the first set index scanning rr_ptr, rr_ptr+1, … mod NREQ. Register it into grant_id, clear burst_cnt, and move to OWN. No beat is accepted in IDLE.
- OWN, combinational outputs:
  - beat = req_valid[grant_id] & ~fifo_full.
  - req_ready[grant_id] = ~fifo_full; all other req_ready bits are 0.
  - fifo_wreq = beat.
  - fifo_wdata = req_data slice of grant_id, driven whenever in OWN.
- OWN transitions, evaluated in priority order:
  1. req_valid[grant_id]=0: release. Go to IDLE, rr_ptr <= grant_id+1 mod NREQ.
  2. beat and burst_cnt==MAX_BURST-1: the final beat is accepted, then release as in (1).
  3. beat: burst_cnt++, stay in OWN.
  4. fifo_full with owner valid: stall. Stay in OWN, burst_cnt unchanged. Fullness never causes a release.
- beat_total increments on every cycle with fifo_wreq=1 and wraps at 2^16.
- Producers must hold req_valid and req_data stable until accepted. The arbiter does not buffer data.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. An in-flight beat in that cycle is not written, because fifo_wreq drops with grant_active.

## Timing

- Reset values: grant_active=0, grant_id=0, req_ready=0, fifo_wreq=0, fifo_wdata=0, beat_total=0. Internally, state=IDLE, rr_ptr=0, burst_cnt=0.
- Arbitration latency is 1 cycle. A request sampled in IDLE at edge N gives grant_active=1 after edge N, and the first beat can be written in cycle N+1.
- Release costs 1 idle cycle: after a release, one cycle is spent in IDLE before the next grant.
- Throughput with continuous valid and no full: MAX_BURST beats per MAX_BURST+1 cycles.
- fifo_full to wreq is combinational, in the same cycle. The FIFO sees no write while full.
- Simultaneous requests: the lowest index at or after rr_ptr wins. The owner just released always gets the lowest priority next round.

## Test plan

- Reset: assert reset_n=0 mid-burst -> all outputs at their reset values in the same cycle, no fifo_wreq. Release reset with req_valid=4'b0001 -> grant_id=0 one cycle later.
- Round-robin: all four producers valid continuously, MAX_BURST=4, fifo_full=0 -> grant order 0,1,2,3,0. Each grant delivers 4 beats, followed by 1 IDLE cycle. beat_total=16 after 20 cycles of ownership plus idle.
- Early release: producer 2 is granted and drops valid after 2 beats -> release, rr_ptr=3. Producer 3 is granted next even though producer 0 is also valid.
- Full stall: owner valid, fifo_full=1 for 5 cycles -> fifo_wreq=0 and req_ready=0, grant held, burst_cnt frozen. When full clears, the remaining beats complete the 4-beat burst.
- Data routing: producer 1 offers 0xA5 and producer 3 offers 0x3C, both valid, with rr_ptr=2 -> fifo_wdata=0x3C on the first beat. 0xA5 is written on producer 1's later grant.
- beat_total wrap: preload by 65535 beats -> the next beat yields beat_total=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter for the write port of one shared synchronous FIFO.
//   NREQ producers offer beats on valid/ready. One producer at a time owns
//   the port for a burst of up to MAX_BURST beats. Accepted beats go to the
//   FIFO write port in the same cycle, and only while the FIFO is not full.
//
// Handshake: a beat moves from producer i when req_valid[i] and req_ready[i]
//   are both high at a rising clk edge. req_ready never depends on the
//   producer's own valid, so a producer must hold valid and data stable
//   until it is accepted. Each cycle with fifo_wreq=1 is exactly one beat.
//
// Ports
//   clk, reset_n   clock; asynchronous active-low reset
//   req_valid      per-producer data valid            [NREQ]
//   req_data       producer i at [i*WIDTH +: WIDTH]   [NREQ*WIDTH]
//   req_ready      per-producer accept, one-hot or 0  [NREQ]
//   fifo_full      FIFO full flag
//   fifo_wreq      FIFO write strobe, one beat per high cycle
//   fifo_wdata     FIFO write data                    [WIDTH]
//   grant_active   arbiter FSM is in OWN (exposes FSM state)
//   grant_id       current owner, valid while grant_active=1
//   beat_total     running count of accepted beats, wraps at 2^16
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int MAX_BURST = 4,
  parameter int BCW       = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wreq,
  output logic [WIDTH-1:0]       fifo_wdata,
  output logic                   grant_active,
  output logic [IDW-1:0]         grant_id,
  output logic [15:0]            beat_total
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [IDW-1:0]   grant_n;
  logic [IDW-1:0]   rr_ptr, rr_n;
  logic [IDW-1:0]   pick, scan_idx;
  logic [BCW-1:0]   burst_cnt, burst_n;
  logic             found;
  logic             owner_valid;
  logic             beat;
  logic             last_beat;
  logic [WIDTH-1:0] slot [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slot[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan rr_ptr, rr_ptr+1, ... and take the first valid producer. NREQ is a
  // power of two, so the IDW-bit addition wraps modulo NREQ on its own.
  always_comb begin
    found    = 1'b0;
    pick     = rr_ptr;
    scan_idx = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = rr_ptr + IDW'(k);
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  assign grant_active = (state == OWN);
  assign owner_valid  = req_valid[grant_id];
  // fifo_full gates the write combinationally so a full FIFO never sees one.
  assign beat         = grant_active & owner_valid & ~fifo_full;
  assign last_beat    = (burst_cnt == BCW'(MAX_BURST - 1));
  assign fifo_wreq    = beat;
  assign fifo_wdata   = grant_active ? slot[grant_id] : '0;

  always_comb begin
    req_ready = '0;
    if (grant_active) begin
      req_ready[grant_id] = ~fifo_full;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    rr_n    = rr_ptr;
    burst_n = burst_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = OWN;
          grant_n = pick;
          burst_n = '0;
        end
      end
      OWN: begin
        // Owner dropping valid or finishing its burst releases the port and
        // moves the owner to the lowest priority. A stall keeps everything.
        if (!owner_valid || (beat && last_beat)) begin
          state_n = IDLE;
          rr_n    = grant_id + IDW'(1);
        end else if (beat) begin
          burst_n = burst_cnt + BCW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      beat_total <= '0;
    end else begin
      state     <= state_n;
      grant_id  <= grant_n;
      rr_ptr    <= rr_n;
      burst_cnt <= burst_n;
      if (fifo_wreq) begin
        beat_total <= beat_total + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Drives fifo_wr_arbiter with directed scenarios and random producer
//   traffic. A cycle-level reference model (owner as an int, -1 for none)
//   predicts every cycle's outputs and every written beat; a monitor on the
//   falling edge pops and compares.
module tb_fifo_wr_arbiter;
  localparam int WIDTH     = 8;
  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int MAX_BURST = 4;
  localparam int BCW       = 3;
  localparam int RW        = 3 + IDW + NREQ + WIDTH + 16;
  localparam int BW        = IDW + WIDTH;

  // clock / reset / DUT
  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full = 1'b0;
  logic                  fifo_wreq;
  logic [WIDTH-1:0]      fifo_wdata;
  logic                  grant_active;
  logic [IDW-1:0]        grant_id;
  logic [15:0]           beat_total;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .MAX_BURST(MAX_BURST), .BCW(BCW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wreq(fifo_wreq),
    .fifo_wdata(fifo_wdata), .grant_active(grant_active), .grant_id(grant_id),
    .beat_total(beat_total)
  );

  // scoreboard state
  logic [RW-1:0]    exp_q[$];   // per-cycle expected outputs
  logic [BW-1:0]    beat_q[$];  // expected written beats {producer, data}
  int               n_chk = 0;
  int               n_fail = 0;
  logic             run = 1'b1;

  // producer data, reference model
  logic [WIDTH-1:0] pd[NREQ];
  logic [WIDTH-1:0] pd_next[NREQ];
  logic [NREQ-1:0]  acc = '0;   // producers whose beat the model accepted
  int               m_owner = -1;
  int               m_next = 0;
  int               m_beats = 0;
  logic [15:0]      m_total = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one cycle, evaluated on the inputs applied for that cycle.
  task automatic step();
    logic            e_chk, e_wreq, e_act;
    logic [NREQ-1:0] e_rdy;
    logic [WIDTH-1:0] e_wd;
    logic [IDW-1:0]  e_id;
    logic            ov, bt;
    acc = '0;
    if (!reset_n) begin
      exp_q.push_back({1'b1, {(RW-1){1'b0}}});
      m_owner = -1; m_next = 0; m_beats = 0; m_total = '0;
      return;
    end
    if (m_owner < 0) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, {IDW{1'b0}}, {NREQ{1'b0}}, {WIDTH{1'b0}}, m_total});
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[(m_next + k) % NREQ]) begin
          m_owner = (m_next + k) % NREQ;
          m_beats = 0;
          break;
        end
      end
    end else begin
      ov    = req_valid[m_owner];
      bt    = ov && !fifo_full;
      e_chk = 1'b1; e_wreq = bt; e_act = 1'b1;
      e_id  = IDW'(m_owner);
      e_rdy = '0;
      e_rdy[m_owner] = !fifo_full;
      e_wd  = pd[m_owner];
      exp_q.push_back({e_chk, e_wreq, e_act, e_id, e_rdy, e_wd, m_total});
      if (bt) begin
        beat_q.push_back({e_id, e_wd});
        acc[m_owner] = 1'b1;
        m_total = m_total + 16'd1;
        m_beats++;
      end
      if (!ov || m_beats == MAX_BURST) begin
        m_next  = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  // driver: apply one cycle of inputs just after the rising edge
  task automatic tick(input logic rn, input logic [NREQ-1:0] v, input logic f);
    @(posedge clk); #1;
    reset_n   = rn;
    fifo_full = f;
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      pd[i] = pd_next[i];
      req_data[i*WIDTH +: WIDTH] = pd[i];
    end
    step();
  endtask

  task automatic do_reset();
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
  endtask

  // random producers: hold until accepted, then maybe offer a new beat
  task automatic rand_cycle();
    logic [NREQ-1:0] nv;
    logic            f, rn;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !acc[i]) begin
        nv[i] = 1'b1;
      end else if (req_valid[i]) begin
        nv[i] = ($urandom_range(3) != 0);
        if (nv[i]) pd_next[i] = WIDTH'($urandom);
      end else begin
        nv[i] = ($urandom_range(2) == 0);
        if (nv[i]) pd_next[i] = WIDTH'($urandom);
      end
    end
    f  = ($urandom_range(4) == 0);
    rn = ($urandom_range(300) != 0);
    tick(rn, nv, f);
  endtask

  // monitor / scoreboard
  initial begin
    logic            e_chk, e_wreq, e_act;
    logic [IDW-1:0]  e_id;
    logic [NREQ-1:0] e_rdy;
    logic [WIDTH-1:0] e_wd;
    logic [15:0]     e_tot;
    logic [BW-1:0]   b;
    forever begin
      @(negedge clk);
      if (run) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          {e_chk, e_wreq, e_act, e_id, e_rdy, e_wd, e_tot} = exp_q.pop_front();
          check("fifo_wreq", 32'(fifo_wreq), 32'(e_wreq));
          check("grant_active", 32'(grant_active), 32'(e_act));
          check("req_ready", 32'(req_ready), 32'(e_rdy));
          check("beat_total", 32'(beat_total), 32'(e_tot));
          if (e_chk) begin
            check("grant_id", 32'(grant_id), 32'(e_id));
            check("fifo_wdata", 32'(fifo_wdata), 32'(e_wd));
          end
        end
        if (fifo_wreq) begin
          if (beat_q.size() == 0) begin
            check("unexpected_write", 32'(fifo_wdata), 32'hFFFF_FFFF);
          end else begin
            b = beat_q.pop_front();
            check("write_beat", 32'({grant_id, fifo_wdata}), 32'(b));
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pd[i] = '0;
      pd_next[i] = WIDTH'(8'h10 + i);
    end

    // reset values
    tick(1'b0, '0, 1'b0);
    @(negedge clk);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_fifo_wreq", 32'(fifo_wreq), 32'd0);
    check("rst_fifo_wdata", 32'(fifo_wdata), 32'd0);
    check("rst_beat_total", 32'(beat_total), 32'd0);

    // round robin, all valid: 0,1,2,3 each 4 beats plus one idle cycle
    do_reset();
    for (int c = 1; c <= 21; c++) tick(1'b1, 4'b1111, 1'b0);
    @(negedge clk);
    check("rr_total_16", 32'(beat_total), 32'd16);
    check("rr_idle_gap", 32'(grant_active), 32'd0);
    tick(1'b1, 4'b1111, 1'b0);
    @(negedge clk);
    check("rr_wrap_active", 32'(grant_active), 32'd1);
    check("rr_wrap_to_0", 32'(grant_id), 32'd0);

    // early release: producer 2 drops after 2 beats, 3 beats 0
    do_reset();
    tick(1'b1, 4'b0100, 1'b0);
    tick(1'b1, 4'b0100, 1'b0);
    tick(1'b1, 4'b0100, 1'b0);
    tick(1'b1, 4'b1001, 1'b0);
    tick(1'b1, 4'b1001, 1'b0);
    @(negedge clk);
    check("early_total", 32'(beat_total), 32'd2);
    tick(1'b1, 4'b1001, 1'b0);
    @(negedge clk);
    check("early_next_owner", 32'(grant_id), 32'd3);

    // full stall for 5 cycles in the middle of a burst
    do_reset();
    tick(1'b1, 4'b0001, 1'b0);
    tick(1'b1, 4'b0001, 1'b0);
    for (int c = 0; c < 5; c++) tick(1'b1, 4'b0001, 1'b1);
    @(negedge clk);
    check("stall_wreq", 32'(fifo_wreq), 32'd0);
    check("stall_ready", 32'(req_ready), 32'd0);
    check("stall_held", 32'(grant_active), 32'd1);
    for (int c = 0; c < 3; c++) tick(1'b1, 4'b0001, 1'b0);
    tick(1'b1, 4'b0001, 1'b0);
    @(negedge clk);
    check("stall_release", 32'(grant_active), 32'd0);
    check("stall_total", 32'(beat_total), 32'd4);

    // reset in the middle of a beat
    tick(1'b1, 4'b0001, 1'b0);
    tick(1'b0, 4'b0001, 1'b0);
    @(negedge clk);
    check("midrst_wreq", 32'(fifo_wreq), 32'd0);
    check("midrst_active", 32'(grant_active), 32'd0);
    check("midrst_total", 32'(beat_total), 32'd0);
    tick(1'b1, 4'b0001, 1'b0);
    tick(1'b1, 4'b0001, 1'b0);
    @(negedge clk);
    check("post_rst_grant", 32'({grant_active, grant_id}), 32'({1'b1, 2'd0}));

    // data routing with rr_ptr=2: 0x3C first, 0xA5 on producer 1's grant
    do_reset();
    tick(1'b1, 4'b0010, 1'b0);
    tick(1'b1, 4'b0000, 1'b0);
    pd_next[1] = 8'hA5;
    pd_next[3] = 8'h3C;
    tick(1'b1, 4'b1010, 1'b0);
    tick(1'b1, 4'b1010, 1'b0);
    @(negedge clk);
    check("route_first_data", 32'(fifo_wdata), 32'h3C);
    check("route_first_wreq", 32'(fifo_wreq), 32'd1);
    for (int c = 0; c < 5; c++) tick(1'b1, 4'b1010, 1'b0);
    @(negedge clk);
    check("route_second_data", 32'(fifo_wdata), 32'hA5);
    check("route_second_id", 32'(grant_id), 32'd1);

    // random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) rand_cycle();
    tick(1'b1, '0, 1'b0);
    tick(1'b1, '0, 1'b0);

    @(negedge clk); #1;
    run = 1'b0;
    check("beats_outstanding", 32'(beat_q.size()), 32'd0);
    check("cycles_outstanding", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
